// File: rtl/skin_bbox.sv
// Skin-pixel counter and bounding-box accumulator over a raster-scanned frame.
// Emits one result per completed frame on a valid/ready port.
module skin_bbox #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 16,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int CW        = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic          skind,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          o_found,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [YW-1:0] o_ymin,
  output logic [YW-1:0] o_ymax,
  output logic [CW-1:0] o_count,
  output logic          o_drop
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_q, any_d;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

  logic          vld_q, vld_d, drop_q, drop_d;
  logic          fnd_q, fnd_d;
  logic [XW-1:0] rxmin_q, rxmin_d, rxmax_q, rxmax_d;
  logic [YW-1:0] rymin_q, rymin_d, rymax_q, rymax_d;
  logic [CW-1:0] rcnt_q, rcnt_d;

  logic          take, hit, last, found_n;
  logic [XW-1:0] px, bxmin, bxmax, nxmin, nxmax;
  logic [YW-1:0] py, bymin, bymax, nymin, nymax;
  logic [CW-1:0] bcnt, ncnt;
  logic          bany, nany;

  // A sof pixel restarts the frame, so it sees cleared accumulators at (0,0).
  always_comb begin
    take  = i_valid && (i_sof || state_q == S_ACC);
    px    = i_sof ? '0 : x_q;
    py    = i_sof ? '0 : y_q;
    bcnt  = i_sof ? '0 : cnt_q;
    bany  = i_sof ? 1'b0 : any_q;
    bxmin = i_sof ? '0 : xmin_q;
    bxmax = i_sof ? '0 : xmax_q;
    bymin = i_sof ? '0 : ymin_q;
    bymax = i_sof ? '0 : ymax_q;
    hit   = take && skind;
    ncnt  = bcnt;
    if (hit && bcnt != {CW{1'b1}}) ncnt = bcnt + CW'(1);
    nany  = bany || hit;
    nxmin = (hit && (!bany || px < bxmin)) ? px : bxmin;
    nxmax = (hit && (!bany || px > bxmax)) ? px : bxmax;
    nymin = (hit && (!bany || py < bymin)) ? py : bymin;
    nymax = (hit && (!bany || py > bymax)) ? py : bymax;
    last  = take && px == XW'(H_ACTIVE - 1)
                 && py == YW'(V_ACTIVE - 1);
    found_n = ncnt >= CW'(MIN_COUNT);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    any_d   = any_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    if (take) begin
      if (last) begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
        cnt_d   = '0;
        any_d   = 1'b0;
        xmin_d  = '0;
        xmax_d  = '0;
        ymin_d  = '0;
        ymax_d  = '0;
      end else begin
        state_d = S_ACC;
        x_d     = (px == XW'(H_ACTIVE - 1)) ? '0 : px + XW'(1);
        y_d     = (px == XW'(H_ACTIVE - 1)) ? py + YW'(1) : py;
        cnt_d   = ncnt;
        any_d   = nany;
        xmin_d  = nxmin;
        xmax_d  = nxmax;
        ymin_d  = nymin;
        ymax_d  = nymax;
      end
    end
  end

  always_comb begin
    vld_d   = vld_q && !o_ready;
    drop_d  = 1'b0;
    fnd_d   = fnd_q;
    rxmin_d = rxmin_q;
    rxmax_d = rxmax_q;
    rymin_d = rymin_q;
    rymax_d = rymax_q;
    rcnt_d  = rcnt_q;
    if (last) begin
      vld_d   = 1'b1;
      drop_d  = vld_q && !o_ready;
      fnd_d   = found_n;
      rxmin_d = found_n ? nxmin : '0;
      rxmax_d = found_n ? nxmax : '0;
      rymin_d = found_n ? nymin : '0;
      rymax_d = found_n ? nymax : '0;
      rcnt_d  = ncnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      any_q   <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      vld_q   <= 1'b0;
      drop_q  <= 1'b0;
      fnd_q   <= 1'b0;
      rxmin_q <= '0;
      rxmax_q <= '0;
      rymin_q <= '0;
      rymax_q <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      any_q   <= any_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      vld_q   <= vld_d;
      drop_q  <= drop_d;
      fnd_q   <= fnd_d;
      rxmin_q <= rxmin_d;
      rxmax_q <= rxmax_d;
      rymin_q <= rymin_d;
      rymax_q <= rymax_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign o_valid = vld_q;
  assign o_drop  = drop_q;
  assign o_found = fnd_q;
  assign o_xmin  = rxmin_q;
  assign o_xmax  = rxmax_q;
  assign o_ymin  = rymin_q;
  assign o_ymax  = rymax_q;
  assign o_count = rcnt_q;

endmodule
